// File: rtl/rtc_bus_ctrl.sv
// Multiplexed address/data bus master for the RTC: one flag_rtc edge produces one timed
// address phase followed by a write or read data phase. siga stays high while busy.
module rtc_bus_ctrl #(
   parameter int unsigned T_SETUP = 2,
   parameter int unsigned T_PULSE = 10,
   parameter int unsigned T_GAP   = 5
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       flag_rtc,
   input  logic       lea_escriba,
   input  logic [7:0] direc,
   input  logic [7:0] dato_dmyd,
   input  logic [7:0] ad_in,
   output logic [7:0] ad_out,
   output logic       ad_oe,
   output logic       cs_n,
   output logic       wr_n,
   output logic       rd_n,
   output logic       a_d,
   output logic       siga,
   output logic [7:0] dato_leido,
   output logic       leido_valid
);

   typedef enum logic [3:0] {
      IDLE, ARM, A_SETUP, A_STROBE, A_HOLD, D_SETUP, D_STROBE, D_HOLD, DONE
   } state_t;

   localparam logic [7:0] SETUP_M1 = 8'(T_SETUP - 1);
   localparam logic [7:0] PULSE_M1 = 8'(T_PULSE - 1);
   localparam logic [7:0] GAP_M1   = 8'(T_GAP - 1);

   state_t     state, state_nxt;
   logic [7:0] cnt, cnt_nxt;
   logic       flag_d;
   logic       req;
   logic       last;
   logic [7:0] addr_r;
   logic [7:0] data_r;
   logic       wr_r;

   assign req  = flag_rtc & ~flag_d;
   assign last = (cnt == 8'd0);
   assign siga = (state != IDLE);

   // Counter is loaded with (duration - 1) whenever a state is entered.
   function automatic logic [7:0] load_val(input state_t s);
      case (s)
         ARM:                load_val = SETUP_M1;
         A_STROBE, D_STROBE: load_val = PULSE_M1;
         A_HOLD, D_HOLD:     load_val = GAP_M1;
         default:            load_val = 8'd0;
      endcase
   endfunction

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= IDLE;
         cnt   <= 8'd0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end

   always_comb begin
      state_nxt   = state;
      cnt_nxt     = 8'd0;
      ad_oe       = 1'b0;
      ad_out      = 8'h00;
      cs_n        = 1'b1;
      wr_n        = 1'b1;
      rd_n        = 1'b1;
      a_d         = 1'b1;
      leido_valid = 1'b0;

      case (state)
         IDLE:     if (req) state_nxt = ARM;
         ARM:      if (last) state_nxt = A_SETUP;
         A_SETUP:  state_nxt = A_STROBE;
         A_STROBE: if (last) state_nxt = A_HOLD;
         A_HOLD:   if (last) state_nxt = D_SETUP;
         D_SETUP:  state_nxt = D_STROBE;
         D_STROBE: if (last) state_nxt = D_HOLD;
         D_HOLD:   if (last) state_nxt = DONE;
         DONE:     state_nxt = IDLE;
         default:  state_nxt = IDLE;
      endcase

      if (state_nxt != state)
         cnt_nxt = load_val(state_nxt);
      else if (state != IDLE)
         cnt_nxt = cnt - 8'd1;

      case (state)
         A_SETUP, A_HOLD: begin
            ad_oe  = 1'b1;
            ad_out = addr_r;
            a_d    = 1'b0;
         end
         A_STROBE: begin
            ad_oe  = 1'b1;
            ad_out = addr_r;
            a_d    = 1'b0;
            cs_n   = 1'b0;
            wr_n   = 1'b0;
         end
         D_SETUP, D_HOLD: begin
            ad_oe  = wr_r;
            ad_out = wr_r ? data_r : 8'h00;
         end
         D_STROBE: begin
            ad_oe  = wr_r;
            ad_out = wr_r ? data_r : 8'h00;
            cs_n   = 1'b0;
            wr_n   = ~wr_r;
            rd_n   = wr_r;
         end
         DONE:    leido_valid = ~wr_r;
         default: ;
      endcase
   end

   // Unknown lea_escriba falls to the else branch, so it is treated as a read.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         flag_d     <= 1'b0;
         addr_r     <= 8'h00;
         data_r     <= 8'h00;
         wr_r       <= 1'b0;
         dato_leido <= 8'h00;
      end else begin
         flag_d <= flag_rtc;
         if (state == ARM && last) begin
            addr_r <= direc;
            data_r <= dato_dmyd;
            if (lea_escriba == 1'b1) wr_r <= 1'b1;
            else                     wr_r <= 1'b0;
         end
         if (state == D_STROBE && last && !wr_r)
            dato_leido <= ad_in;
      end
   end

endmodule

// File: tb/tb_rtc_bus_ctrl.sv
// Bench for rtc_bus_ctrl: default-timing and all-ones-timing instances share inputs; outputs
// are compared every cycle against a phase-table model of the bus waveform.
module tb_rtc_bus_ctrl;

   logic       clk = 1'b0;
   logic       reset;
   logic       flag_rtc;
   logic       lea_escriba;
   logic [7:0] direc;
   logic [7:0] dato_dmyd;
   logic [7:0] ad_in;

   logic [7:0] ua_ad_out, ub_ad_out, ua_dato, ub_dato;
   logic       ua_ad_oe, ua_cs_n, ua_wr_n, ua_rd_n, ua_a_d, ua_siga, ua_lv;
   logic       ub_ad_oe, ub_cs_n, ub_wr_n, ub_rd_n, ub_a_d, ub_siga, ub_lv;

   int         checks   = 0;
   int         failures = 0;
   logic [7:0] model_dato [2];
   logic [8:0] mon_q[$];
   bit         mon_en  = 1'b0;
   logic       prev_cs = 1'b1;

   localparam logic [14:0] IDLE_VEC = 15'b0_00000000_1_1_1_1_0_0;

   always #5 clk = ~clk;

   rtc_bus_ctrl u_a (
      .clk(clk), .reset(reset), .flag_rtc(flag_rtc), .lea_escriba(lea_escriba),
      .direc(direc), .dato_dmyd(dato_dmyd), .ad_in(ad_in), .ad_out(ua_ad_out),
      .ad_oe(ua_ad_oe), .cs_n(ua_cs_n), .wr_n(ua_wr_n), .rd_n(ua_rd_n), .a_d(ua_a_d),
      .siga(ua_siga), .dato_leido(ua_dato), .leido_valid(ua_lv)
   );

   rtc_bus_ctrl #(.T_SETUP(1), .T_PULSE(1), .T_GAP(1)) u_b (
      .clk(clk), .reset(reset), .flag_rtc(flag_rtc), .lea_escriba(lea_escriba),
      .direc(direc), .dato_dmyd(dato_dmyd), .ad_in(ad_in), .ad_out(ub_ad_out),
      .ad_oe(ub_ad_oe), .cs_n(ub_cs_n), .wr_n(ub_wr_n), .rd_n(ub_rd_n), .a_d(ub_a_d),
      .siga(ub_siga), .dato_leido(ub_dato), .leido_valid(ub_lv)
   );

   // Records the bus value at the start of every chip-select strobe.
   always @(negedge clk) begin
      if (mon_en && ua_cs_n == 1'b0 && prev_cs == 1'b1)
         mon_q.push_back({ua_a_d, ua_ad_out});
      prev_cs = ua_cs_n;
   end

   function automatic logic [14:0] obs(input bit sel);
      if (sel) return {ub_ad_oe, ub_ad_out, ub_cs_n, ub_wr_n, ub_rd_n, ub_a_d, ub_siga, ub_lv};
      return {ua_ad_oe, ua_ad_out, ua_cs_n, ua_wr_n, ua_rd_n, ua_a_d, ua_siga, ua_lv};
   endfunction

   // Expected outputs k cycles after siga rises: setup window, address phase, data phase, done.
   function automatic logic [14:0] exp_vec(input int k, input int ts, input int tp, input int tg,
                                           input bit wr, input logic [7:0] addr,
                                           input logic [7:0] data);
      logic       oe, cs, w, r, ad, sg, lv;
      logic [7:0] o;
      int         p, q;
      oe = 1'b0; o = 8'h00; cs = 1'b1; w = 1'b1; r = 1'b1; ad = 1'b1; sg = 1'b0; lv = 1'b0;
      p = k - ts;
      q = p - (1 + tp + tg);
      if (k >= 0 && k < ts + 2*tp + 2*tg + 3) sg = 1'b1;
      if (p >= 0 && p <= tp + tg) begin
         oe = 1'b1; o = addr; ad = 1'b0;
         if (p >= 1 && p <= tp) begin cs = 1'b0; w = 1'b0; end
      end else if (q >= 0 && q <= tp + tg) begin
         oe = wr; o = wr ? data : 8'h00;
         if (q >= 1 && q <= tp) begin
            cs = 1'b0;
            if (wr) w = 1'b0; else r = 1'b0;
         end
      end else if (q == tp + tg + 1) begin
         lv = !wr;
      end
      return {oe, o, cs, w, r, ad, sg, lv};
   endfunction

   // One request; flag held for 'hold' cycles, optional extra edge at cycle edge_at.
   task automatic run_txn(input bit sel, input bit wr, input logic [7:0] addr,
                          input logic [7:0] data, input int hold, input int edge_at,
                          input int rd_val, input string name);
      int         ts, tp, tg, len, klast, n;
      logic [7:0] cap, exp_d, got_d;
      logic [14:0] e, o;
      ts = sel ? 1 : 2; tp = sel ? 1 : 10; tg = sel ? 1 : 5;
      len   = ts + 2*tp + 2*tg + 3;
      klast = ts + 1 + tp + tg + tp;
      n     = (hold + 2 > len + 2) ? hold + 2 : len + 2;
      cap   = 8'h00;
      @(negedge clk);
      flag_rtc = 1'b1;
      for (int k = 0; k < n; k++) begin
         @(negedge clk);
         e = exp_vec(k, ts, tp, tg, wr, addr, data);
         o = obs(sel);
         checks++;
         if (o !== e) begin
            failures++;
            $display("FAIL %s bus k=%0d got=%h want=%h", name, k, o, e);
         end
         exp_d = (!wr && k > klast) ? cap : model_dato[sel];
         got_d = sel ? ub_dato : ua_dato;
         checks++;
         if (got_d !== exp_d) begin
            failures++;
            $display("FAIL %s dato_leido k=%0d got=%h want=%h", name, k, got_d, exp_d);
         end
         if (k == 0) begin
            direc = addr; dato_dmyd = data; lea_escriba = wr;
         end
         if (k == ts) begin
            direc = 8'($urandom); dato_dmyd = 8'($urandom); lea_escriba = 1'($urandom);
         end
         ad_in = 8'($urandom);
         if (k == klast) begin
            if (rd_val >= 0) ad_in = 8'(rd_val);
            cap = ad_in;
         end
         flag_rtc = (k + 1 < hold) || (k == edge_at);
      end
      if (!wr) model_dato[sel] = cap;
   endtask

   task automatic test_reset();
      flag_rtc = 1'b1;
      @(negedge clk);
      flag_rtc = 1'b0;
      @(negedge clk);
      checks++;
      if (obs(0) !== IDLE_VEC) begin
         failures++; $display("FAIL reset_a got=%h want=%h", obs(0), IDLE_VEC);
      end
      checks++;
      if (obs(1) !== IDLE_VEC) begin
         failures++; $display("FAIL reset_b got=%h want=%h", obs(1), IDLE_VEC);
      end
      checks++;
      if (ua_dato !== 8'h00 || ub_dato !== 8'h00) begin
         failures++; $display("FAIL reset_dato got=%h/%h want=00", ua_dato, ub_dato);
      end
      reset = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_write();
      run_txn(0, 1'b1, 8'h24, 8'h15, 1, -1, -1, "write");
   endtask

   task automatic test_read();
      run_txn(0, 1'b0, 8'h21, 8'h00, 1, -1, 8'h59, "read");
      checks++;
      if (ua_dato !== 8'h59) begin
         failures++; $display("FAIL read_value got=%h want=59", ua_dato);
      end
   endtask

   task automatic test_upstream();
      logic [7:0] addrs [5];
      logic [7:0] datas [5];
      logic [8:0] want;
      addrs = '{8'h24, 8'h25, 8'h26, 8'h27, 8'hF1};
      mon_q.delete();
      mon_en = 1'b1;
      for (int i = 0; i < 5; i++) begin
         datas[i] = (i == 4) ? 8'h00 : 8'($urandom);
         run_txn(0, 1'b1, addrs[i], datas[i], 1, -1, -1, "upstream");
      end
      mon_en = 1'b0;
      checks++;
      if (mon_q.size() != 10) begin
         failures++; $display("FAIL upstream_count got=%0d want=10", mon_q.size());
      end else begin
         for (int i = 0; i < 10; i++) begin
            want = (i % 2 == 0) ? {1'b0, addrs[i/2]} : {1'b1, datas[i/2]};
            checks++;
            if (mon_q[i] !== want) begin
               failures++; $display("FAIL upstream_order i=%0d got=%h want=%h", i, mon_q[i], want);
            end
         end
      end
   endtask

   task automatic test_held_and_busy_edges();
      run_txn(0, 1'b1, 8'($urandom), 8'($urandom), 100, -1, -1, "held_level");
      run_txn(0, 1'b0, 8'($urandom), 8'h00, 1, 10, -1, "busy_edge");
      run_txn(0, 1'b1, 8'($urandom), 8'($urandom), 1, 34, -1, "done_edge");
   endtask

   task automatic test_random();
      for (int i = 0; i < 6; i++)
         run_txn(0, 1'($urandom), 8'($urandom), 8'($urandom), $urandom_range(1, 3), -1, -1,
                 "random");
   endtask

   task automatic test_reset_mid();
      @(negedge clk);
      flag_rtc = 1'b1;
      @(negedge clk);
      flag_rtc = 1'b0; direc = 8'h3C; dato_dmyd = 8'hA5; lea_escriba = 1'b1;
      repeat (4) @(negedge clk);
      #2 reset = 1'b0;
      #1;
      checks++;
      if ({ua_cs_n, ua_wr_n, ua_ad_oe, ua_siga} !== 4'b1100) begin
         failures++;
         $display("FAIL reset_mid got=%b want=1100", {ua_cs_n, ua_wr_n, ua_ad_oe, ua_siga});
      end
      model_dato[0] = 8'h00;
      model_dato[1] = 8'h00;
      @(negedge clk);
      reset = 1'b1;
      run_txn(0, 1'b0, 8'h30, 8'h00, 1, -1, -1, "after_reset");
   endtask

   task automatic test_params();
      repeat (2) @(negedge clk);
      reset = 1'b0;
      model_dato[0] = 8'h00;
      model_dato[1] = 8'h00;
      @(negedge clk);
      reset = 1'b1;
      run_txn(1, 1'b1, 8'h24, 8'h15, 1, -1, -1, "param_write");
      run_txn(1, 1'b0, 8'h21, 8'h00, 1, -1, 8'h59, "param_read");
      for (int i = 0; i < 4; i++)
         run_txn(1, 1'($urandom), 8'($urandom), 8'($urandom), 1, -1, -1, "param_random");
   endtask

   initial begin
      reset = 1'b1; flag_rtc = 1'b0; lea_escriba = 1'b0;
      direc = 8'h00; dato_dmyd = 8'h00; ad_in = 8'h00;
      model_dato[0] = 8'h00;
      model_dato[1] = 8'h00;
      #3 reset = 1'b0;
      repeat (2) @(negedge clk);
      test_reset();
      test_write();
      test_read();
      test_upstream();
      test_held_and_busy_edges();
      test_random();
      test_reset_mid();
      test_params();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/rtc_bus_ctrl.md
Name: rtc_bus_ctrl

Overview:
- Downstream consumer of the date/time writer FSMs. Turns one request (flag_rtc pulse plus direc, dato_dmyd and lea_escriba) into one multiplexed address/data bus cycle on the RTC: address phase, then data phase, write or read.
- Returns the busy handshake siga, which the upstream FSMs poll before issuing their next access.
- The tri-state pad is instantiated at top level; this block exposes split ad_out/ad_oe/ad_in.

Parameters:
- T_SETUP, 2: cycles between request detect and capture of direc/dato_dmyd/lea_escriba. Upstream loads these one cycle after its flag pulse. Legal range 1..255.
- T_PULSE, 10: cycles cs_n plus wr_n/rd_n are held low in each phase. Legal range 1..255.
- T_GAP, 5: cycles strobes are high with bus held after each strobe. Legal range 1..255.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- flag_rtc  in  1  access request; rising edge starts a transaction
- lea_escriba  in  1  1 = write; any other value (0/X/Z) = read
- direc  in  8  RTC register address
- dato_dmyd  in  8  write data
- ad_in  in  8  bus value from pad
- ad_out  out  8  bus value to pad
- ad_oe  out  1  1 = drive pad
- cs_n  out  1  chip select, active-low
- wr_n  out  1  write strobe, active-low
- rd_n  out  1  read strobe, active-low
- a_d  out  1  0 = address phase, 1 = data phase
- siga  out  1  1 while a transaction is in progress
- dato_leido  out  8  last read data
- leido_valid  out  1  one-cycle pulse when dato_leido updates

Behaviour:
- Request detection
  - Internal register flag_d samples flag_rtc every cycle.
  - req = flag_rtc & ~flag_d.
  - req is acted on only in IDLE. Edges while busy are ignored and not queued.
  - A level held high never retriggers.
- State machine, one 8-bit down-counter for all timed states:
  - IDLE: on req go to ARM.
  - ARM (T_SETUP cycles): on the last cycle capture addr_r=direc, data_r=dato_dmyd, wr_r=(lea_escriba==1).
  - A_SETUP (1): ad_oe=1, ad_out=addr_r, a_d=0.
  - A_STROBE (T_PULSE): as A_SETUP, plus cs_n=0, wr_n=0.
  - A_HOLD (T_GAP): strobes high, address still driven.
  - D_SETUP (1): a_d=1.
    - Write: ad_oe=1, ad_out=data_r.
    - Read: ad_oe=0.
  - D_STROBE (T_PULSE): cs_n=0.
    - Write: wr_n=0.
    - Read: rd_n=0; ad_in is captured into dato_leido on the last cycle.
  - D_HOLD (T_GAP): strobes high; write keeps data driven, read keeps ad_oe=0.
  - DONE (1): ad_oe=0, a_d=1. leido_valid=1 if the access was a read. Then IDLE.
- Output rules
  - Outputs are Moore-decoded from state and captured registers.
  - wr_n and rd_n are never low together.
  - cs_n is low only in the two STROBE states.
- IDLE / reset values: cs_n=1, wr_n=1, rd_n=1, a_d=1, ad_oe=0, ad_out=0x00, siga=0, dato_leido=0x00, leido_valid=0, flag_d=0. Captured registers reset to 0.
- siga timing
  - siga = (state != IDLE), so it rises the cycle after req is sampled.
  - It stays high for T_SETUP+2*T_PULSE+2*T_GAP+3 cycles (35 with defaults).
  - It falls in the same cycle the FSM returns to IDLE.
- Read data: dato_leido holds its value until the next read completes. Writes do not modify it.
- Reset mid-operation: all outputs go to IDLE values immediately (asynchronous). The bus is released and no pending request is retained.
- Simultaneous events: a req edge in the same cycle DONE→IDLE is ignored; the FSM is not in IDLE when it is sampled.
- Counter: loaded with (duration−1) on state entry; the state advances when the counter reads 0.

Test Plan:
- Write: flag_rtc one-cycle pulse; direc=0x24, dato_dmyd=0x15, lea_escriba=1 one cycle later.
  - Address phase: ad_out=0x24, a_d=0, wr_n low 10 cycles.
  - Data phase: ad_out=0x15, a_d=1, wr_n low 10 cycles.
  - rd_n stays 1; siga high exactly 35 cycles; no leido_valid.
- Read: direc=0x21, lea_escriba=0, ad_in=0x59 during the data strobe.
  - ad_oe=0 from D_SETUP through DONE; rd_n low 10 cycles.
  - dato_leido=0x59 with a 1-cycle leido_valid in DONE.
- Upstream emulation: writes to 0x24/0x25/0x26/0x27 then 0xF1/0x00, each issued after siga falls.
  - Exactly five address/data pairs appear on the bus, in that order.
- Held level and busy edge: flag_rtc held high 100 cycles gives exactly one transaction.
  - A second edge at cycle 10 of a transaction is ignored; siga shows one 35-cycle high window.
- Reset: reset=0 during A_STROBE gives cs_n=1, wr_n=1, ad_oe=0, siga=0 within the same cycle.
  - After release, the next request completes normally.
- Parameters: T_SETUP=1, T_PULSE=1, T_GAP=1 gives siga high 8 cycles, with each strobe exactly one cycle wide.
